uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
Parametrised UART receiver, successor to uart_rx.
- Generalised in data width, parity mode and stop-bit count.
- Adds glitch-rejecting start detection, parity/framing error flags, break detection and an input synchroniser.
- Sits between the pad-side serial line and the byte-level consumer (command decoder or FIFO), driven from the same system clock as uart_tx.

Parameters:
CLKS_PER_BIT, 87, system clocks per bit period; minimum 4.
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
STOP_BITS, 1, stop bits checked; 1 or 2.

Ports:
i_Clock  in  1  system clock; all logic on rising edge.
i_Rst_n  in  1  reset; asynchronous, active-low.
i_Rx_Serial  in  1  asynchronous serial line; idle high.
o_Rx_DV  out  1  one-cycle pulse when a frame completes (good or bad).
o_Rx_Byte  out  DATA_BITS  received data, LSB first on the line; held until next o_Rx_DV.
o_Parity_Err  out  1  parity mismatch on the last frame; valid with o_Rx_DV, held until next o_Rx_DV; always 0 when PARITY=0.
o_Frame_Err  out  1  any stop bit sampled 0 on the last frame; same timing as o_Parity_Err.
o_Break  out  1  last frame was all-zero data, zero parity bit (if present) and zero stop; same timing.
o_Rx_Active  out  1  high from validated start bit until return to IDLE.

Behaviour:
Reset
- i_Rst_n low forces: o_Rx_DV=0, o_Rx_Byte=0, all error flags=0, o_Rx_Active=0, state IDLE, counters=0, synchroniser flops=1.
- Reset mid-frame abandons the frame silently; no DV.

Synchroniser and sampling
- 2-flop synchroniser on i_Rx_Serial. All sampling uses the synchronised signal, so there is 2 cycles of input latency.
- Clock counter width is $clog2(CLKS_PER_BIT). Bit index width is $clog2(DATA_BITS).

State machine
- IDLE: synchronised line = 0 -> START, counter cleared.
- START: at counter = CLKS_PER_BIT/2 - 1 (mid start bit), re-sample. If line is 0 -> DATA, counter cleared, o_Rx_Active=1. If line is 1 -> IDLE (glitch rejected, no outputs change).
- DATA: sample every CLKS_PER_BIT clocks (mid-bit) into shift position bit_index. After bit DATA_BITS-1, go to PARITY if PARITY != 0, else STOP.
- PARITY: sample one bit at mid-bit.
  - Even mode: error if XOR of data bits and the parity bit is 1.
  - Odd mode: error if that XOR is 0.
- STOP: sample STOP_BITS bits at mid-bit. Any 0 sets the frame error. After the last stop sample -> CLEANUP.
- CLEANUP, one cycle:
  - o_Rx_DV=1; o_Rx_Byte and flags updated on the same edge.
  - Frame error clear -> IDLE.
  - Frame error set -> WAIT_IDLE.
- WAIT_IDLE: stay until synchronised line = 1, then IDLE. This prevents a held-low line (break) from retriggering; o_Rx_Active=0.

Timing
- o_Rx_DV rises on the clock edge after the mid-sample of the last stop bit. It is never high for more than 1 cycle.
- Back-to-back frames: a new start edge arriving immediately after a good stop bit is accepted. IDLE is re-entered within half a bit period.

Decomposition:
- Shared package uart_pkg:
  - parity mode constants PAR_NONE/PAR_ODD/PAR_EVEN;
  - state encoding for IDLE, START, DATA, PARITY, STOP, CLEANUP, WAIT_IDLE;
  - reused by uart_tx successor.
- One sub-module: uart_sync2, a 2-flop synchroniser with async active-low reset to 1.

Test Plan:
Common settings: CLKS_PER_BIT=4, 16 ns bit period, serial-write task driving i_Rx_Serial.

1. PARITY=0, DATA_BITS=8: send 0x05 -> exactly one o_Rx_DV pulse, o_Rx_Byte=0x05, all flags 0; then send 0xC9 back-to-back -> second pulse, byte 0xC9.
2. PARITY=2: send 0xC9 with parity bit 0 -> byte 0xC9, o_Parity_Err=0. Resend with parity bit 1 -> byte 0xC9, o_Parity_Err=1. Next good frame clears the flag.
3. PARITY=1, STOP_BITS=2: send 0xAB with second stop bit 0 -> o_Frame_Err=1, byte 0xAB. Line returns high, send 0x3F -> clean receive, flags 0.
4. Glitch: drive line 0 for 1 clock in IDLE -> no o_Rx_DV, o_Rx_Active stays 0. A following 0x55 frame is received correctly.
5. Break: hold line 0 for 12 bit periods -> one o_Rx_DV with byte 0x00, o_Frame_Err=1, o_Break=1. No further DV until line is high and a new frame arrives.
6. Reset mid-frame: pulse i_Rst_n low during data bit 3 of 0xA5 -> all outputs 0, no DV. Then DATA_BITS=7 build: send 0x3F -> byte 7'h3F, flags 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver/transmitter state encoding
// and the parity check helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_CLEANUP,
    ST_WAIT_IDLE
  } uart_state_e;

  // ones_odd is the XOR of the data bits and the received parity bit
  function automatic logic parity_error(input int mode, input logic ones_odd);
    case (mode)
      PAR_ODD:  return !ones_odd;
      PAR_EVEN: return ones_odd;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for the idle-high serial line; resets to the idle level.
module uart_sync2 (
  input  logic i_Clock,
  input  logic i_Rst_n,
  input  logic line_async,
  output logic line_sync
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
    end else begin
      meta_reg <= line_async;
      sync_reg <= meta_reg;
    end
  end

  assign line_sync = sync_reg;

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: glitch-rejecting start detection, parity and
// framing error flags, break detection, two-flop input synchroniser.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Rx_Active
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  logic rx_sync;

  uart_state_e state_reg, state_next;
  logic [CNT_W-1:0]     clk_cnt_reg, clk_cnt_next;
  logic [IDX_W-1:0]     bit_idx_reg, bit_idx_next;
  logic                 stop_idx_reg, stop_idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 par_bit_reg, par_bit_next;
  logic                 ferr_acc_reg, ferr_acc_next;
  logic                 stop_zero_reg, stop_zero_next;

  logic                 dv_reg, dv_next;
  logic [DATA_BITS-1:0] byte_reg, byte_next;
  logic                 perr_reg, perr_next;
  logic                 ferr_reg, ferr_next;
  logic                 brk_reg, brk_next;
  logic                 active_reg, active_next;

  uart_sync2 u_sync (
    .i_Clock    (i_Clock),
    .i_Rst_n    (i_Rst_n),
    .line_async (i_Rx_Serial),
    .line_sync  (rx_sync)
  );

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_reg     <= ST_IDLE;
      clk_cnt_reg   <= '0;
      bit_idx_reg   <= '0;
      stop_idx_reg  <= 1'b0;
      shift_reg     <= '0;
      par_bit_reg   <= 1'b0;
      ferr_acc_reg  <= 1'b0;
      stop_zero_reg <= 1'b0;
      dv_reg        <= 1'b0;
      byte_reg      <= '0;
      perr_reg      <= 1'b0;
      ferr_reg      <= 1'b0;
      brk_reg       <= 1'b0;
      active_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      clk_cnt_reg   <= clk_cnt_next;
      bit_idx_reg   <= bit_idx_next;
      stop_idx_reg  <= stop_idx_next;
      shift_reg     <= shift_next;
      par_bit_reg   <= par_bit_next;
      ferr_acc_reg  <= ferr_acc_next;
      stop_zero_reg <= stop_zero_next;
      dv_reg        <= dv_next;
      byte_reg      <= byte_next;
      perr_reg      <= perr_next;
      ferr_reg      <= ferr_next;
      brk_reg       <= brk_next;
      active_reg    <= active_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    clk_cnt_next   = clk_cnt_reg;
    bit_idx_next   = bit_idx_reg;
    stop_idx_next  = stop_idx_reg;
    shift_next     = shift_reg;
    par_bit_next   = par_bit_reg;
    ferr_acc_next  = ferr_acc_reg;
    stop_zero_next = stop_zero_reg;
    dv_next        = 1'b0;
    byte_next      = byte_reg;
    perr_next      = perr_reg;
    ferr_next      = ferr_reg;
    brk_next       = brk_reg;
    active_next    = active_reg;

    case (state_reg)
      ST_IDLE: begin
        clk_cnt_next   = '0;
        bit_idx_next   = '0;
        stop_idx_next  = 1'b0;
        ferr_acc_next  = 1'b0;
        stop_zero_next = 1'b1;
        if (!rx_sync) state_next = ST_START;
      end

      // Re-check the line at mid start bit so a short low pulse is ignored
      ST_START: begin
        if (clk_cnt_reg == CNT_MID) begin
          clk_cnt_next = '0;
          if (!rx_sync) begin
            state_next  = ST_DATA;
            active_next = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          clk_cnt_next = clk_cnt_reg + CNT_W'(1);
        end
      end

      // Right-shift so the first (LSB) bit lands at position 0 after the last sample
      ST_DATA: begin
        if (clk_cnt_reg == CNT_LAST) begin
          clk_cnt_next = '0;
          shift_next   = {rx_sync, shift_reg[DATA_BITS-1:1]};
          if (bit_idx_reg == IDX_LAST) begin
            bit_idx_next = '0;
            state_next   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_next = bit_idx_reg + IDX_W'(1);
          end
        end else begin
          clk_cnt_next = clk_cnt_reg + CNT_W'(1);
        end
      end

      ST_PARITY: begin
        if (clk_cnt_reg == CNT_LAST) begin
          clk_cnt_next = '0;
          par_bit_next = rx_sync;
          state_next   = ST_STOP;
        end else begin
          clk_cnt_next = clk_cnt_reg + CNT_W'(1);
        end
      end

      ST_STOP: begin
        if (clk_cnt_reg == CNT_LAST) begin
          clk_cnt_next = '0;
          if (!rx_sync) ferr_acc_next = 1'b1;
          else          stop_zero_next = 1'b0;
          if (stop_idx_reg == STOP_LAST) state_next = ST_CLEANUP;
          else                           stop_idx_next = 1'b1;
        end else begin
          clk_cnt_next = clk_cnt_reg + CNT_W'(1);
        end
      end

      ST_CLEANUP: begin
        dv_next     = 1'b1;
        byte_next   = shift_reg;
        perr_next   = parity_error(PARITY, ^{shift_reg, par_bit_reg});
        ferr_next   = ferr_acc_reg;
        brk_next    = (shift_reg == '0) && stop_zero_reg &&
                      ((PARITY == PAR_NONE) || !par_bit_reg);
        active_next = 1'b0;
        state_next  = ferr_acc_reg ? ST_WAIT_IDLE : ST_IDLE;
      end

      // A line held low after a bad stop must not look like a fresh start edge
      ST_WAIT_IDLE: begin
        if (rx_sync) state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign o_Rx_DV      = dv_reg;
  assign o_Rx_Byte    = byte_reg;
  assign o_Parity_Err = perr_reg;
  assign o_Frame_Err  = ferr_reg;
  assign o_Break      = brk_reg;
  assign o_Rx_Active  = active_reg;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench: four receiver configurations, frames built from a bit-level
// line model, expected results queued at issue and checked by a monitor on DV.
module tb_uart_rx_cfg;

  localparam int CPB = 4;

  logic clk = 1'b0;
  always #2 clk = ~clk;

  logic       rst_n;
  logic [3:0] rx_line;
  logic [3:0] dv, perr, ferr, brk, act;
  logic [7:0] byte_a, byte_b, byte_c;
  logic [6:0] byte_d;
  logic [8:0] byte_w [4];

  // instance 0: 8N1, 1: 8E1, 2: 8O2, 3: 7N1
  int cfg_db  [4] = '{8, 8, 8, 7};
  int cfg_par [4] = '{0, 2, 1, 0};
  int cfg_sb  [4] = '{1, 1, 2, 1};

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx_line[0]), .o_Rx_DV(dv[0]),
    .o_Rx_Byte(byte_a), .o_Parity_Err(perr[0]), .o_Frame_Err(ferr[0]),
    .o_Break(brk[0]), .o_Rx_Active(act[0]));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_b (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx_line[1]), .o_Rx_DV(dv[1]),
    .o_Rx_Byte(byte_b), .o_Parity_Err(perr[1]), .o_Frame_Err(ferr[1]),
    .o_Break(brk[1]), .o_Rx_Active(act[1]));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u_c (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx_line[2]), .o_Rx_DV(dv[2]),
    .o_Rx_Byte(byte_c), .o_Parity_Err(perr[2]), .o_Frame_Err(ferr[2]),
    .o_Break(brk[2]), .o_Rx_Active(act[2]));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(1)) u_d (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx_line[3]), .o_Rx_DV(dv[3]),
    .o_Rx_Byte(byte_d), .o_Parity_Err(perr[3]), .o_Frame_Err(ferr[3]),
    .o_Break(brk[3]), .o_Rx_Active(act[3]));

  assign byte_w[0] = {1'b0, byte_a};
  assign byte_w[1] = {1'b0, byte_b};
  assign byte_w[2] = {1'b0, byte_c};
  assign byte_w[3] = {2'b00, byte_d};

  typedef struct {
    int         inst;
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [3:0] dv_prev = '0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
    n_checks++;
    if (actual !== required) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, required, $time);
    end
  endtask

  // Monitor: every DV must match the oldest queued expectation
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (dv[i]) begin
        check("dv_single_cycle", 32'(dv_prev[i]), 32'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_dv: inst %0d byte 0x%0h, expected no DV", i, byte_w[i]);
        end else begin
          mon_e = exp_q.pop_front();
          check("dv_inst", i, mon_e.inst);
          check("rx_byte", 32'(byte_w[i]), 32'(mon_e.data));
          check("parity_err", 32'(perr[i]), 32'(mon_e.perr));
          check("frame_err", 32'(ferr[i]), 32'(mon_e.ferr));
          check("break", 32'(brk[i]), 32'(mon_e.brk));
          $display("rx inst %0d byte 0x%0h perr %0b ferr %0b brk %0b", i, byte_w[i],
                   perr[i], ferr[i], brk[i]);
        end
      end
    end
    dv_prev <= dv;
  end

  task automatic drive_bit(input int inst, input logic b);
    rx_line[inst] = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Line-level model: the frame is described as bits on the wire, and the
  // expected flags follow directly from counting ones and inspecting stop bits.
  task automatic send_frame(input int inst, input logic [8:0] data_in, input bit pflip,
                            input logic [1:0] stop_val, input int extra_low, input int gap_bits);
    int db, par, sb, ones;
    logic [8:0] d;
    logic pbit;
    exp_t e;
    db   = cfg_db[inst];
    par  = cfg_par[inst];
    sb   = cfg_sb[inst];
    d    = data_in & 9'((1 << db) - 1);
    ones = $countones(d);
    pbit = (par == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
    pbit = pbit ^ pflip;
    e.inst = inst;
    e.data = d;
    e.perr = (par == 0) ? 1'b0 :
             (par == 2) ? ((ones + int'(pbit)) % 2 == 1) : ((ones + int'(pbit)) % 2 == 0);
    e.ferr = !stop_val[0] || (sb == 2 && !stop_val[1]);
    e.brk  = (d == 0) && (par == 0 || !pbit) && !stop_val[0] && (sb == 1 || !stop_val[1]);
    exp_q.push_back(e);
    drive_bit(inst, 1'b0);
    for (int i = 0; i < db; i++) drive_bit(inst, d[i]);
    if (par != 0) drive_bit(inst, pbit);
    for (int s = 0; s < sb; s++) drive_bit(inst, stop_val[s]);
    for (int k = 0; k < extra_low; k++) drive_bit(inst, 1'b0);
    for (int k = 0; k < gap_bits; k++) drive_bit(inst, 1'b1);
  endtask

  // Line held low for 12 bit periods in total
  task automatic send_break(input int inst);
    int len;
    len = 1 + cfg_db[inst] + ((cfg_par[inst] != 0) ? 1 : 0) + cfg_sb[inst];
    send_frame(inst, 9'h000, cfg_par[inst] == 1, 2'b00, 12 - len, 2);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check("pending_frames", exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_dv"}, 32'(dv[i]), 0);
      check({tag, "_byte"}, 32'(byte_w[i]), 0);
      check({tag, "_flags"}, 32'({perr[i], ferr[i], brk[i]}), 0);
      check({tag, "_active"}, 32'(act[i]), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] sv;
    bit pf, fe;
    bit act_seen;
    logic [7:0] a5;
    rst_n   = 1'b0;
    rx_line = 4'hF;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: two back-to-back 8N1 frames
    send_frame(0, 9'h05, 0, 2'b11, 0, 0);
    send_frame(0, 9'hC9, 0, 2'b11, 0, 2);
    wait_drain();

    // 2: even parity good, bad, good
    send_frame(1, 9'hC9, 0, 2'b11, 0, 1);
    send_frame(1, 9'hC9, 1, 2'b11, 0, 1);
    send_frame(1, 9'h12, 0, 2'b11, 0, 2);
    wait_drain();

    // 3: odd parity, two stops, second stop low, then a clean frame
    send_frame(2, 9'hAB, 0, 2'b01, 0, 2);
    send_frame(2, 9'h3F, 0, 2'b11, 0, 2);
    wait_drain();

    // 4: one-clock glitch must not start a frame
    rx_line[0] = 1'b0;
    @(negedge clk);
    rx_line[0] = 1'b1;
    act_seen = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      act_seen |= act[0];
    end
    check("glitch_active", 32'(act_seen), 0);
    send_frame(0, 9'h55, 0, 2'b11, 0, 2);
    wait_drain();

    // randomized traffic on every configuration
    for (int inst = 0; inst < 4; inst++) begin
      for (int n = 0; n < 20; n++) begin
        sv = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
        pf = (cfg_par[inst] != 0) && ($urandom_range(0, 3) == 0);
        fe = !sv[0] || (cfg_sb[inst] == 2 && !sv[1]);
        send_frame(inst, 9'($urandom_range(0, 511)), pf, sv, 0,
                   fe ? 1 : $urandom_range(0, 1));
      end
      drive_bit(inst, 1'b1);
      wait_drain();
    end

    // 5: break on 8N1 then normal frame; break on 8O2 left as last frame
    send_break(0);
    repeat (6 * CPB) @(negedge clk);
    send_frame(0, 9'h5A, 0, 2'b11, 0, 2);
    wait_drain();
    send_break(2);
    wait_drain();

    // 6: reset during data bit 3 of 0xA5 on instance 0
    a5 = 8'hA5;
    drive_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(0, a5[i]);
    rx_line[0] = a5[3];
    repeat (2) @(negedge clk);
    check("active_mid_frame", 32'(act[0]), 1);
    rst_n      = 1'b0;
    rx_line[0] = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    check("no_dv_after_reset", exp_q.size(), 0);
    send_frame(3, 9'h3F, 0, 2'b11, 0, 2);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
